// File: rtl/jtframe_ram_rqc.sv
// SDRAM request adapter for one game-side client: turns a level addr_ok into req/req_rnw,
// returns data with a held (or pulsed) data_ok, and keeps an optional one-word read cache.
module jtframe_ram_rqc #(
    parameter int unsigned AW      = 18,
    parameter int unsigned DW      = 8,
    parameter int unsigned CACHE   = 1,
    parameter int unsigned OKLATCH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [21:0]   offset,
    input  logic          addr_ok,
    input  logic          wrin,
    input  logic [DW-1:0] wrdata,
    input  logic [31:0]   din,
    input  logic          din_ok,
    input  logic          we,
    output logic          req,
    output logic          req_rnw,
    output logic [21:0]   sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_wrmask,
    output logic          data_ok,
    output logic [DW-1:0] dout
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          rnw_q, rnw_d;
    logic          data_ok_q, data_ok_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [21:0]   saddr_q, saddr_d;
    logic [15:0]   sdin_q, sdin_d;
    logic [1:0]    mask_q, mask_d;
    logic          sel_q, sel_d;
    logic          valid_q, valid_d;
    logic [21:0]   tag_q, tag_d;
    logic [31:0]   cache_q, cache_d;
    logic [AW-1:0] addr_q;
    logic          aok_q;

    logic [21:0]   waddr;
    logic [DW-1:0] lane_din, lane_hit;
    logic [15:0]   wr_din;
    logic [1:0]    wr_mask;
    logic          rd;
    logic          trigger, hit, done;

    if (DW == 8) begin : g_dw8
        assign waddr    = 22'(addr >> 1) + offset;
        assign lane_din = sel_q   ? din[15:8]     : din[7:0];
        assign lane_hit = addr[0] ? cache_q[15:8] : cache_q[7:0];
        assign wr_din   = {wrdata, wrdata};
        assign wr_mask  = addr[0] ? 2'b10 : 2'b01;
        assign rd       = ~wrin;
    end else if (DW == 16) begin : g_dw16
        assign waddr    = 22'(addr) + offset;
        assign lane_din = din[15:0];
        assign lane_hit = cache_q[15:0];
        assign wr_din   = wrdata;
        assign wr_mask  = 2'b11;
        assign rd       = ~wrin;
    end else begin : g_dw32
        // 32-bit clients are read-only: wrin is ignored
        assign waddr    = (22'(addr) << 1) + offset;
        assign lane_din = din;
        assign lane_hit = cache_q;
        assign wr_din   = 16'd0;
        assign wr_mask  = 2'b00;
        assign rd       = 1'b1;
    end

    assign trigger = addr_ok && (!aok_q || addr != addr_q);
    assign hit     = (CACHE != 0) && valid_q && (tag_q == waddr) && rd;
    assign done    = din_ok && we;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rnw_d     = rnw_q;
        data_ok_d = data_ok_q;
        dout_d    = dout_q;
        saddr_d   = saddr_q;
        sdin_d    = sdin_q;
        mask_d    = mask_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        cache_d   = cache_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (trigger) begin
                    if (hit) begin
                        data_ok_d = 1'b1;
                        dout_d    = lane_hit;
                        state_d   = StDone;
                    end else begin
                        req_d     = 1'b1;
                        rnw_d     = rd;
                        data_ok_d = 1'b0;
                        saddr_d   = waddr;
                        sel_d     = addr[0];
                        if (!rd) begin
                            sdin_d = wr_din;
                            mask_d = wr_mask;
                        end
                        state_d   = StReq;
                    end
                end else if (!addr_ok) begin
                    data_ok_d = 1'b0;
                    state_d   = StIdle;
                end else if (OKLATCH == 0) begin
                    data_ok_d = 1'b0;
                end
            end
            StReq: begin
                if (done) begin
                    req_d = 1'b0;
                    rnw_d = 1'b1;
                    if (rnw_q) begin
                        dout_d  = lane_din;
                        cache_d = din;
                        tag_d   = saddr_q;
                        valid_d = (CACHE != 0);
                    end else if (tag_q == saddr_q) begin
                        valid_d = 1'b0;
                    end
                    // A client that already let go gets no completion strobe
                    data_ok_d = addr_ok;
                    state_d   = addr_ok ? StDone : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            rnw_q     <= 1'b1;
            data_ok_q <= 1'b0;
            dout_q    <= '0;
            saddr_q   <= '0;
            sdin_q    <= '0;
            mask_q    <= '0;
            sel_q     <= 1'b0;
            valid_q   <= 1'b0;
            tag_q     <= '0;
            cache_q   <= '0;
            addr_q    <= '0;
            aok_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rnw_q     <= rnw_d;
            data_ok_q <= data_ok_d;
            dout_q    <= dout_d;
            saddr_q   <= saddr_d;
            sdin_q    <= sdin_d;
            mask_q    <= mask_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            cache_q   <= cache_d;
            addr_q    <= addr;
            aok_q     <= addr_ok;
        end
    end

    assign req          = req_q;
    assign req_rnw      = rnw_q;
    assign sdram_addr   = saddr_q;
    assign sdram_din    = sdin_q;
    assign sdram_wrmask = mask_q;
    assign data_ok      = data_ok_q;
    assign dout         = dout_q;

endmodule

// File: tb/tb_jtframe_ram_rqc.sv
// Bench for jtframe_ram_rqc: 8-bit cached client scored through an expected-data queue,
// plus a 32-bit and a 16-bit (pulsed data_ok) instance checked directly.
module tb_jtframe_ram_rqc;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        wrin;
    logic [31:0] wrdata;
    logic [31:0] din;
    logic        din_ok, we;
    logic        aok8, aok32, aok16;
    logic [21:0] off8, off32, off16;

    logic        req8, rnw8, dok8;
    logic [21:0] sa8;
    logic [15:0] sd8;
    logic [1:0]  mk8;
    logic [7:0]  dout8;
    logic        req32, rnw32, dok32;
    logic [21:0] sa32;
    logic [15:0] sd32;
    logic [1:0]  mk32;
    logic [31:0] dout32;
    logic        req16, rnw16, dok16;
    logic [21:0] sa16;
    logic [15:0] sd16;
    logic [1:0]  mk16;
    logic [15:0] dout16;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        dok8_prev = 1'b0;

    always #5 clk = ~clk;

    jtframe_ram_rqc #(.AW(18), .DW(8), .CACHE(1), .OKLATCH(1)) u_dut8 (
        .clk(clk), .rst(rst), .addr(addr), .offset(off8), .addr_ok(aok8), .wrin(wrin),
        .wrdata(wrdata[7:0]), .din(din), .din_ok(din_ok), .we(we), .req(req8),
        .req_rnw(rnw8), .sdram_addr(sa8), .sdram_din(sd8), .sdram_wrmask(mk8),
        .data_ok(dok8), .dout(dout8)
    );

    jtframe_ram_rqc #(.AW(18), .DW(32), .CACHE(1), .OKLATCH(1)) u_dut32 (
        .clk(clk), .rst(rst), .addr(addr), .offset(off32), .addr_ok(aok32), .wrin(wrin),
        .wrdata(wrdata), .din(din), .din_ok(din_ok), .we(we), .req(req32),
        .req_rnw(rnw32), .sdram_addr(sa32), .sdram_din(sd32), .sdram_wrmask(mk32),
        .data_ok(dok32), .dout(dout32)
    );

    jtframe_ram_rqc #(.AW(18), .DW(16), .CACHE(1), .OKLATCH(0)) u_dut16 (
        .clk(clk), .rst(rst), .addr(addr), .offset(off16), .addr_ok(aok16), .wrin(wrin),
        .wrdata(wrdata[15:0]), .din(din), .din_ok(din_ok), .we(we), .req(req16),
        .req_rnw(rnw16), .sdram_addr(sa16), .sdram_din(sd16), .sdram_wrmask(mk16),
        .data_ok(dok16), .dout(dout16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle granted completion from the SDRAM side
    task automatic complete(input logic [31:0] data);
        din    = data;
        din_ok = 1'b1;
        we     = 1'b1;
        step();
        din_ok = 1'b0;
        we     = 1'b0;
    endtask

    // Scoreboard: every data_ok rise on the 8-bit client consumes one expected dout
    always @(negedge clk) begin
        if (dok8 && !dok8_prev) begin
            if (exp_q.size() == 0) begin
                check("dout8_unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                check("dout8_scoreboard", {24'd0, dout8}, exp_q.pop_front());
            end
        end
        dok8_prev <= dok8;
    end

    initial begin
        rst = 1'b1; addr = '0; wrin = 1'b0; wrdata = '0; din = '0; din_ok = 1'b0; we = 1'b0;
        aok8 = 1'b0; aok32 = 1'b0; aok16 = 1'b0;
        off8 = 22'h100; off32 = 22'h0; off16 = 22'h3FFFFF;
        repeat (3) step();
        check("rst_req", {31'd0, req8}, 32'd0);
        check("rst_rnw", {31'd0, rnw8}, 32'd1);
        check("rst_data_ok", {31'd0, dok8}, 32'd0);
        check("rst_dout", {24'd0, dout8}, 32'd0);
        check("rst_sdram_addr", {10'd0, sa8}, 32'd0);
        check("rst_sdram_din", {16'd0, sd8}, 32'd0);
        check("rst_wrmask", {30'd0, mk8}, 32'd0);
        rst = 1'b0;
        step();

        // Read miss, completion four cycles after the request
        addr = 18'h5; aok8 = 1'b1; exp_q.push_back(32'hC3);
        step();
        check("rd_req", {31'd0, req8}, 32'd1);
        check("rd_rnw", {31'd0, rnw8}, 32'd1);
        check("rd_sdram_addr", {10'd0, sa8}, 32'h102);
        check("rd_data_ok_early", {31'd0, dok8}, 32'd0);
        repeat (3) step();
        complete(32'hA1B2_C3D4);
        check("rd_req_drop", {31'd0, req8}, 32'd0);
        check("rd_data_ok", {31'd0, dok8}, 32'd1);
        repeat (2) step();
        check("rd_data_ok_held", {31'd0, dok8}, 32'd1);
        aok8 = 1'b0;
        step();
        check("rd_data_ok_release", {31'd0, dok8}, 32'd0);

        // Cache hit on the other byte of the same word
        addr = 18'h4; aok8 = 1'b1; exp_q.push_back(32'hD4);
        step();
        check("hit_no_req", {31'd0, req8}, 32'd0);
        check("hit_data_ok", {31'd0, dok8}, 32'd1);
        aok8 = 1'b0;
        step();

        // Byte write to the upper lane; dout must stay at the last read value
        addr = 18'h5; wrin = 1'b1; wrdata = 32'h7E; aok8 = 1'b1; exp_q.push_back(32'hD4);
        step();
        check("wr_req", {31'd0, req8}, 32'd1);
        check("wr_rnw", {31'd0, rnw8}, 32'd0);
        check("wr_sdram_din", {16'd0, sd8}, 32'h7E7E);
        check("wr_wrmask", {30'd0, mk8}, 32'h2);
        complete(32'hFFFF_FFFF);
        check("wr_sdram_din_held", {16'd0, sd8}, 32'h7E7E);
        aok8 = 1'b0; wrin = 1'b0;
        step();

        // The write invalidated the cached word
        addr = 18'h5; aok8 = 1'b1; exp_q.push_back(32'h7E);
        step();
        check("rd_after_wr_miss", {31'd0, req8}, 32'd1);
        complete(32'h1122_7E44);
        aok8 = 1'b0;
        step();

        // Client lets go before completion: completion is absorbed silently
        addr = 18'h10; aok8 = 1'b1;
        step();
        check("abs_req", {31'd0, req8}, 32'd1);
        aok8 = 1'b0;
        step();
        check("abs_req_held", {31'd0, req8}, 32'd1);
        complete(32'h0000_0099);
        check("abs_req_drop", {31'd0, req8}, 32'd0);
        check("abs_data_ok", {31'd0, dok8}, 32'd0);

        // Ungranted din_ok is ignored, then reset aborts the request
        addr = 18'h8; aok8 = 1'b1;
        step();
        din_ok = 1'b1; we = 1'b0;
        step();
        check("nowe_req", {31'd0, req8}, 32'd1);
        check("nowe_data_ok", {31'd0, dok8}, 32'd0);
        din_ok = 1'b0; rst = 1'b1; aok8 = 1'b0;
        step();
        check("abort_req", {31'd0, req8}, 32'd0);
        check("abort_data_ok", {31'd0, dok8}, 32'd0);
        rst = 1'b0;
        step();
        // Word 0x108 was cached by the absorbed read; reset must have dropped it
        addr = 18'h10; aok8 = 1'b1; exp_q.push_back(32'h55);
        step();
        check("post_rst_miss", {31'd0, req8}, 32'd1);
        complete(32'h0000_0055);
        aok8 = 1'b0;
        step();

        // 32-bit client: wrin ignored, address doubled
        addr = 18'h3; wrin = 1'b1; aok32 = 1'b1;
        step();
        check("dw32_req", {31'd0, req32}, 32'd1);
        check("dw32_rnw", {31'd0, rnw32}, 32'd1);
        check("dw32_sdram_addr", {10'd0, sa32}, 32'h6);
        complete(32'hDEAD_BEEF);
        check("dw32_data_ok", {31'd0, dok32}, 32'd1);
        check("dw32_dout", dout32, 32'hDEAD_BEEF);
        aok32 = 1'b0; wrin = 1'b0;
        step();
        check("dw32_release", {31'd0, dok32}, 32'd0);

        // 16-bit client: address wraps, data_ok is a single-cycle pulse
        addr = 18'h2; aok16 = 1'b1;
        step();
        check("dw16_req", {31'd0, req16}, 32'd1);
        check("dw16_wrap_addr", {10'd0, sa16}, 32'h1);
        complete(32'h0000_BEEF);
        check("dw16_data_ok", {31'd0, dok16}, 32'd1);
        check("dw16_dout", {16'd0, dout16}, 32'hBEEF);
        step();
        check("dw16_pulse_end", {31'd0, dok16}, 32'd0);
        step();
        check("dw16_stay_low", {31'd0, dok16}, 32'd0);
        check("dw16_no_req", {31'd0, req16}, 32'd0);
        aok16 = 1'b0;
        repeat (2) step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_ram_rqc.md
Name: jtframe_ram_rqc

Overview:
Parametrised SDRAM request adapter for one game-side client. It supports 8-, 16- or 32-bit clients, byte-lane writes and an optional single-entry read cache. It turns a level-type client strobe (addr_ok) into a req/req_rnw request towards the SDRAM arbiter, then returns data through a held data_ok strobe. It sits between a core bus client and the jtframe SDRAM controller slot.

Parameters:
AW, 18, client address width, in DW-sized units
DW, 8, client data width; legal values 8, 16, 32
CACHE, 1, 1 keeps the last read 32-bit word so a repeat read completes without SDRAM access; 0 disables the cache
OKLATCH, 1, 1 holds data_ok until addr_ok falls; 0 gives a one-cycle data_ok pulse

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
addr  in  AW  client address, in DW units
offset  in  22  SDRAM base, 16-bit word units; static during play
addr_ok  in  1  client request valid (level)
wrin  in  1  1 = write; sampled with the request; ignored when DW=32
wrdata  in  DW  client write data
din  in  32  SDRAM read data; din[15:0] = word at sdram_addr, din[31:16] = word at sdram_addr+1
din_ok  in  1  SDRAM data/completion strobe
we  in  1  slot grant: din_ok belongs to this client
req  out  1  request to arbiter
req_rnw  out  1  1 = read, 0 = write
sdram_addr  out  22  SDRAM word address
sdram_din  out  16  write data to SDRAM
sdram_wrmask  out  2  active-high byte enables; bit1 = [15:8], bit0 = [7:0]
data_ok  out  1  client data valid / write done
dout  out  DW  client read data

Behaviour:
- Reset values: req=0, req_rnw=1, data_ok=0, dout=0, sdram_addr=0, sdram_din=0, sdram_wrmask=0, cache valid=0, FSM=IDLE. Reset takes effect on the next clk edge and aborts any transaction; no completion is reported for an aborted transaction.
- Word address, 22-bit, wraps mod 2^22:
  - DW=8: (addr>>1)+offset; byte select = addr[0].
  - DW=16: addr+offset.
  - DW=32: (addr<<1)+offset.
- Trigger: in IDLE or DONE, a rising edge of addr_ok, or an addr change while addr_ok=1, starts a transaction. An addr change is ignored while in REQ.
- FSM IDLE/DONE -> REQ when the trigger is a read that misses the cache, or any write. In the same edge: req=1, req_rnw=~wrin (forced to 1 when DW=32), data_ok=0, sdram_addr latched.
- Cache hit (CACHE=1, valid, latched word address equals the stored tag, read):
  - FSM -> DONE with no req.
  - data_ok=1 and dout set at the same edge the trigger is sampled, i.e. 1 cycle after addr_ok rises.
- Write data, DW=8: sdram_din = {wrdata, wrdata}; sdram_wrmask = addr[0] ? 2'b10 : 2'b01.
- Write data, DW=16: sdram_din = wrdata; sdram_wrmask = 2'b11.
- Write data is latched with the request and held until completion.
- REQ -> DONE on din_ok && we:
  - req=0, req_rnw=1, data_ok=1.
  - Read: dout is the selected lane. DW=8 uses din[15:8] if byte select else din[7:0]; DW=16 uses din[15:0]; DW=32 uses din. The cache stores din and the tag and sets valid.
  - Write: dout unchanged. If the tag matches the written address, cache valid=0.
- din_ok without we is ignored. din_ok && we in IDLE/DONE is ignored and leaves outputs unchanged.
- DONE with OKLATCH=1: data_ok stays 1 until addr_ok=0, then data_ok=0 and FSM -> IDLE.
- DONE with OKLATCH=0: data_ok drops after one cycle; the FSM stays in DONE until addr_ok=0 or a new trigger.
- Simultaneous addr_ok fall and din_ok&&we in REQ: complete the transaction (dout and cache updated), data_ok=0, FSM -> IDLE.
- addr_ok falling in REQ with no completion: req stays 1 until completion. The completion is then absorbed silently (data_ok stays 0).

Test Plan:
- DW=8, offset=22'h100, addr=18'h5, read, din=32'hA1B2_C3D4 on din_ok&&we after 4 cycles -> sdram_addr=22'h102, req_rnw=1, dout=8'hC3, data_ok=1 until addr_ok low, req=0.
- CACHE=1: repeat read of addr=18'h4 after the previous read -> no req, dout=8'hD4, data_ok 1 cycle after addr_ok rise.
- DW=8 write addr=18'h5, wrdata=8'h7E -> req_rnw=0, sdram_din=16'h7E7E, sdram_wrmask=2'b10; a later read of addr 5 misses the cache and issues req.
- DW=32, addr=18'h3, offset=0, wrin=1 -> req_rnw=1, sdram_addr=22'h6, dout=din.
- din_ok=1 with we=0 during REQ -> req stays 1, data_ok=0; rst asserted mid-REQ -> next cycle req=0, data_ok=0, cache invalid.
- offset=22'h3FFFFF, DW=16, addr=18'h2 -> sdram_addr=22'h000001 (wrap); OKLATCH=0 -> data_ok high exactly one cycle.
